// File: rtl/muldiv_seq_unit.sv
// Sequential multiply / divide unit: shift-add MUL and restoring unsigned
// DIV/REM, one bit per cycle, with a valid/ready request and response pair.
//
// state | meaning
// IDLE  | waiting for a request; req_ready high
// MUL   | shift-add multiply, one multiplier bit per cycle
// DIV   | restoring divide, one quotient bit per cycle; an unsupported op
//       | also spends one cycle here so its response comes one edge later
// DONE  | result presented until resp_ready
//
// req_ready is also held low during the rst cycle itself; a request in that
// cycle is ignored anyway, so this only makes the handshake look consistent.
module muldiv_seq_unit #(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic [3:0]   req_op,
    input  logic [N-1:0] req_a,
    input  logic [N-1:0] req_b,
    output logic         resp_valid,
    input  logic         resp_ready,
    output logic [N-1:0] resp_o,
    output logic         resp_err,
    output logic         busy
);

    localparam int CW = $clog2(N + 1);
    localparam logic [CW-1:0] CNT_INIT = CW'(N);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [3:0] OP_MUL = 4'd13;
    localparam logic [3:0] OP_DIV = 4'd14;
    localparam logic [3:0] OP_REM = 4'd15;

    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

    state_t        state_q, state_d;
    logic [3:0]    op_q, op_d;
    logic [N-1:0]  a_q, a_d;      // multiplicand (MUL) / dividend->quotient (DIV)
    logic [N-1:0]  b_q, b_d;      // multiplier (MUL) / divisor (DIV)
    logic [N-1:0]  acc_q, acc_d;  // product (MUL) / partial remainder (DIV)
    logic [CW-1:0] cnt_q, cnt_d;
    logic [N-1:0]  res_q, res_d;
    logic          err_q, err_d;

    logic [N:0]    shifted;
    logic [N:0]    diff;
    logic          qbit;
    logic [N-1:0]  rem_nx;
    logic [N-1:0]  quo_nx;
    logic [N-1:0]  prod_nx;
    logic          last;

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            res_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
            err_q   <= err_d;
        end
    end

    // Next-state and one iteration of the shift-add / restoring-divide datapath.
    // With b = 0 the trial subtraction never goes negative, so the quotient
    // fills with ones and the remainder ends up equal to a without a special case.
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        res_d   = res_q;
        err_d   = err_q;

        shifted = {acc_q, a_q[N-1]};
        diff    = shifted - {1'b0, b_q};
        qbit    = ~diff[N];
        rem_nx  = qbit ? diff[N-1:0] : shifted[N-1:0];
        quo_nx  = {a_q[N-2:0], qbit};
        prod_nx = b_q[0] ? (acc_q + a_q) : acc_q;
        last    = (cnt_q == CNT_ONE);

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    op_d  = req_op;
                    a_d   = req_a;
                    b_d   = req_b;
                    acc_d = '0;
                    cnt_d = CNT_INIT;
                    if (req_op == OP_MUL) begin
                        state_d = MUL;
                        err_d   = 1'b0;
                    end else if (req_op == OP_DIV || req_op == OP_REM) begin
                        state_d = DIV;
                        err_d   = (req_b == '0);
                    end else begin
                        state_d = DIV;
                        cnt_d   = CNT_ONE;
                        err_d   = 1'b1;
                    end
                end
            end
            MUL: begin
                acc_d = prod_nx;
                a_d   = a_q << 1;
                b_d   = b_q >> 1;
                cnt_d = cnt_q - CNT_ONE;
                if (last) begin
                    res_d   = prod_nx;
                    state_d = DONE;
                end
            end
            DIV: begin
                acc_d = rem_nx;
                a_d   = quo_nx;
                cnt_d = cnt_q - CNT_ONE;
                if (last) begin
                    if (op_q == OP_REM)
                        res_d = rem_nx;
                    else if (op_q == OP_DIV)
                        res_d = quo_nx;
                    else
                        res_d = '0;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (resp_ready)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs are forced quiet while rst is high and outside DONE.
    always_comb begin
        req_ready  = (state_q == IDLE) && !rst;
        busy       = (state_q != IDLE) && !rst;
        resp_valid = (state_q == DONE) && !rst;
        resp_o     = resp_valid ? res_q : '0;
        resp_err   = resp_valid && err_q;
    end

endmodule

// File: tb/tb_muldiv_seq_unit.sv
// Directed bench for muldiv_seq_unit (N = 32).
module tb_muldiv_seq_unit;

    localparam int N = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic         req_valid;
    logic         req_ready;
    logic [3:0]   req_op;
    logic [N-1:0] req_a;
    logic [N-1:0] req_b;
    logic         resp_valid;
    logic         resp_ready;
    logic [N-1:0] resp_o;
    logic         resp_err;
    logic         busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    muldiv_seq_unit #(.N(N)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_a      (req_a),
        .req_b      (req_b),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_o     (resp_o),
        .resp_err   (resp_err),
        .busy       (busy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one request (unit must be IDLE), scramble the req_* inputs after
    // the acceptance edge, and count edges until resp_valid (100 = timed out).
    task automatic issue(input logic [3:0] op, input logic [N-1:0] a,
                         input logic [N-1:0] b, output int lat);
        req_valid = 1'b1;
        req_op    = op;
        req_a     = a;
        req_b     = b;
        tick();
        req_valid = 1'b0;
        req_op    = 4'($urandom);
        req_a     = $urandom;
        req_b     = $urandom;
        lat = 0;
        while (resp_valid !== 1'b1 && lat < 100) begin
            tick();
            lat++;
        end
    endtask

    task automatic test_reset();
        rst        = 1'b1;
        req_valid  = 1'b1;
        req_op     = 4'd13;
        req_a      = 32'd7;
        req_b      = 32'd6;
        resp_ready = 1'b1;
        tick();
        tick();
        checks++;
        if (resp_valid !== 1'b0 || resp_o !== '0 || resp_err !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_hold: valid=%b o=%h err=%b busy=%b expected 0 0 0 0",
                     resp_valid, resp_o, resp_err, busy);
        end
        rst       = 1'b0;
        req_valid = 1'b0;
        #1;
        checks++;
        if (req_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: ready=%b busy=%b expected 1 0", req_ready, busy);
        end
        tick();
        checks++;
        if (busy !== 1'b0 || resp_valid !== 1'b0 || resp_o !== '0) begin
            errors++;
            $display("FAIL reset_ignored_req: busy=%b valid=%b o=%h expected 0 0 0",
                     busy, resp_valid, resp_o);
        end
    endtask

    task automatic test_mul();
        logic [N-1:0] va [4];
        logic [N-1:0] vb [4];
        logic [N-1:0] ve [4];
        int lat;
        va = '{32'd7, 32'hFFFF_FFFF, 32'd0, 32'd5};
        vb = '{32'd6, 32'hFFFF_FFFF, 32'd5, 32'd0};
        ve = '{32'd42, 32'd1, 32'd0, 32'd0};
        for (int i = 0; i < 4; i++) begin
            issue(4'd13, va[i], vb[i], lat);
            checks++;
            if (lat !== 32) begin
                errors++;
                $display("FAIL mul_latency[%0d]: got %0d expected 32", i, lat);
            end
            checks++;
            if (resp_o !== ve[i] || resp_err !== 1'b0) begin
                errors++;
                $display("FAIL mul_result[%0d]: got %h err=%b expected %h err=0",
                         i, resp_o, resp_err, ve[i]);
            end
            tick();
            checks++;
            if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
                errors++;
                $display("FAIL mul_consume[%0d]: valid=%b ready=%b expected 0 1",
                         i, resp_valid, req_ready);
            end
        end
    endtask

    task automatic test_div();
        logic [3:0]   vo [6];
        logic [N-1:0] va [6];
        logic [N-1:0] vb [6];
        logic [N-1:0] ve [6];
        int lat;
        vo = '{4'd14, 4'd15, 4'd14, 4'd15, 4'd14, 4'd15};
        va = '{32'd100, 32'd100, 32'd123, 32'd123, 32'd3, 32'd3};
        vb = '{32'd7, 32'd7, 32'd1, 32'd1, 32'd10, 32'd10};
        ve = '{32'd14, 32'd2, 32'd123, 32'd0, 32'd0, 32'd3};
        for (int i = 0; i < 6; i++) begin
            issue(vo[i], va[i], vb[i], lat);
            checks++;
            if (lat !== 32) begin
                errors++;
                $display("FAIL div_latency[%0d]: got %0d expected 32", i, lat);
            end
            checks++;
            if (resp_o !== ve[i] || resp_err !== 1'b0) begin
                errors++;
                $display("FAIL div_result[%0d]: got %h err=%b expected %h err=0",
                         i, resp_o, resp_err, ve[i]);
            end
            tick();
        end
    endtask

    task automatic test_div_zero();
        logic [3:0]   vo [2];
        logic [N-1:0] ve [2];
        int lat;
        vo = '{4'd14, 4'd15};
        ve = '{32'hFFFF_FFFF, 32'd5};
        for (int i = 0; i < 2; i++) begin
            issue(vo[i], 32'd5, 32'd0, lat);
            checks++;
            if (lat !== 32) begin
                errors++;
                $display("FAIL divzero_latency[%0d]: got %0d expected 32", i, lat);
            end
            checks++;
            if (resp_o !== ve[i] || resp_err !== 1'b1) begin
                errors++;
                $display("FAIL divzero_result[%0d]: got %h err=%b expected %h err=1",
                         i, resp_o, resp_err, ve[i]);
            end
            tick();
        end
    endtask

    task automatic test_unsupported();
        logic [3:0] vo [3];
        int lat;
        vo = '{4'd2, 4'd0, 4'd12};
        for (int i = 0; i < 3; i++) begin
            issue(vo[i], 32'd77, 32'd3, lat);
            checks++;
            if (lat !== 1) begin
                errors++;
                $display("FAIL unsup_latency[%0d]: got %0d expected 1", i, lat);
            end
            checks++;
            if (resp_o !== '0 || resp_err !== 1'b1) begin
                errors++;
                $display("FAIL unsup_result[%0d]: got %h err=%b expected 0 err=1",
                         i, resp_o, resp_err);
            end
            tick();
        end
    endtask

    task automatic test_hold();
        int lat;
        int n;
        resp_ready = 1'b0;
        issue(4'd13, 32'd9, 32'd9, lat);
        checks++;
        if (lat !== 32) begin
            errors++;
            $display("FAIL hold_latency: got %0d expected 32", lat);
        end
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (resp_valid !== 1'b1 || resp_o !== 32'd81 || resp_err !== 1'b0 || req_ready !== 1'b0) begin
                errors++;
                $display("FAIL hold_stable[%0d]: valid=%b o=%h err=%b ready=%b expected 1 51 0 0",
                         i, resp_valid, resp_o, resp_err, req_ready);
            end
            tick();
        end
        resp_ready = 1'b1;
        tick();
        checks++;
        if (resp_valid !== 1'b0 || req_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL hold_release: valid=%b ready=%b busy=%b expected 0 1 0",
                     resp_valid, req_ready, busy);
        end
        req_valid = 1'b1;
        req_op    = 4'd13;
        req_a     = 32'd2;
        req_b     = 32'd2;
        tick();
        req_valid = 1'b0;
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL hold_next_accept: busy=%b expected 1", busy);
        end
        n = 0;
        while (resp_valid !== 1'b1 && n < 100) begin
            tick();
            n++;
        end
        checks++;
        if (n !== 32 || resp_o !== 32'd4) begin
            errors++;
            $display("FAIL hold_next_result: lat=%0d o=%h expected 32 4", n, resp_o);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        int lat;
        int n;
        resp_ready = 1'b1;
        issue(4'd13, 32'd3, 32'd5, lat);
        checks++;
        if (lat !== 32 || resp_o !== 32'd15) begin
            errors++;
            $display("FAIL b2b_first: lat=%0d o=%h expected 32 f", lat, resp_o);
        end
        req_valid = 1'b1;
        req_op    = 4'd14;
        req_a     = 32'd50;
        req_b     = 32'd5;
        tick();
        checks++;
        if (busy !== 1'b0 || req_ready !== 1'b1 || resp_valid !== 1'b0) begin
            errors++;
            $display("FAIL b2b_bubble: busy=%b ready=%b valid=%b expected 0 1 0",
                     busy, req_ready, resp_valid);
        end
        tick();
        req_valid = 1'b0;
        req_a     = 32'hDEAD_BEEF;
        req_b     = 32'd0;
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL b2b_accept: busy=%b expected 1", busy);
        end
        n = 0;
        while (resp_valid !== 1'b1 && n < 100) begin
            tick();
            n++;
        end
        checks++;
        if (n !== 32 || resp_o !== 32'd10 || resp_err !== 1'b0) begin
            errors++;
            $display("FAIL b2b_second: lat=%0d o=%h err=%b expected 32 a 0", n, resp_o, resp_err);
        end
        tick();
    endtask

    task automatic test_rst_mid();
        int lat;
        int pulses;
        req_valid = 1'b1;
        req_op    = 4'd14;
        req_a     = 32'd1000;
        req_b     = 32'd3;
        tick();
        req_valid = 1'b0;
        repeat (9) tick();
        rst = 1'b1;
        #1;
        checks++;
        if (resp_valid !== 1'b0 || busy !== 1'b0 || resp_o !== '0 || resp_err !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_during: valid=%b busy=%b o=%h err=%b expected 0 0 0 0",
                     resp_valid, busy, resp_o, resp_err);
        end
        tick();
        rst = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || req_ready !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_idle: busy=%b ready=%b expected 0 1", busy, req_ready);
        end
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (resp_valid === 1'b1) pulses++;
        end
        checks++;
        if (pulses !== 0) begin
            errors++;
            $display("FAIL rstmid_no_resp: got %0d pulses expected 0", pulses);
        end
        issue(4'd13, 32'd3, 32'd4, lat);
        checks++;
        if (lat !== 32 || resp_o !== 32'd12 || resp_err !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_after_mul: lat=%0d o=%h err=%b expected 32 c 0", lat, resp_o, resp_err);
        end
        tick();
    endtask

    initial begin
        rst        = 1'b1;
        req_valid  = 1'b0;
        req_op     = '0;
        req_a      = '0;
        req_b      = '0;
        resp_ready = 1'b1;
        test_reset();
        test_mul();
        test_div();
        test_div_zero();
        test_unsupported();
        test_hold();
        test_back_to_back();
        test_rst_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
